// File: rtl/conv_seq_ctrl_if.sv
// Handshake bundle for conv_seq_ctrl: operand load/start on one side, result stream on the other.
interface conv_seq_ctrl_if #(
    parameter int unsigned N  = 9,
    parameter int unsigned DW = 4,
    parameter int unsigned OW = 12
);
    logic            start;
    logic [N*DW-1:0] a_in;
    logic [N*DW-1:0] b_in;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic [4:0]      out_idx;
    logic            done;

    modport master (
        output start, a_in, b_in, out_ready,
        input  busy, out_valid, out_data, out_idx, done
    );

    modport slave (
        input  start, a_in, b_in, out_ready,
        output busy, out_valid, out_data, out_idx, done
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for 1-D linear convolution: one shared DW x DW multiply-accumulate walks all
// 2N-1 output terms and streams each finished term out over a valid/ready handshake.
module conv_seq_ctrl #(
    parameter int unsigned N  = 9,
    parameter int unsigned DW = 4,
    parameter int unsigned OW = 12
) (
    input logic            clk,
    input logic            rst,
    conv_seq_ctrl_if.slave bus
);
    localparam int unsigned   KW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned   IW       = 5;
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 2);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUT, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] a_q [N];
    logic [DW-1:0] a_d [N];
    logic [DW-1:0] b_q [N];
    logic [DW-1:0] b_d [N];
    logic [IW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_idx_q, out_idx_d;

    logic [KW-1:0]   b_idx;
    logic [2*DW-1:0] prod;
    logic [OW-1:0]   acc_sum;

    // Valid k range for term n: both a[k] and b[n-k] must fall inside 0..N-1.
    function automatic logic [KW-1:0] kmin_f(input logic [IW-1:0] n);
        if (n >= IW'(N)) return KW'(n - IW'(N - 1));
        return '0;
    endfunction

    function automatic logic [KW-1:0] kmax_f(input logic [IW-1:0] n);
        if (n >= IW'(N - 1)) return KW'(N - 1);
        return KW'(n);
    endfunction

    assign b_idx   = KW'(n_q - IW'(k_q));
    assign prod    = a_q[k_q] * b_q[b_idx];
    assign acc_sum = acc_q + OW'(prod);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        a_d[i] = bus.a_in[(N - i) * DW - 1 -: DW];
                        b_d[i] = bus.b_in[(N - i) * DW - 1 -: DW];
                    end
                    n_d     = '0;
                    k_d     = kmin_f('0);
                    acc_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                acc_d = acc_sum;
                if (k_q == kmax_f(n_q)) begin
                    out_data_d = acc_sum;
                    out_idx_d  = n_q;
                    state_d    = S_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (n_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + IW'(1);
                        k_d     = kmin_f(n_q + IW'(1));
                        acc_d   = '0;
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
endmodule
